biquad_sequencer: RTL and testbench

Control and datapath sequencer for one biquad section of the real-time 3-band EQ. It holds the filter history (x[n-1], x[n-2], y[n-1], y[n-2]) and the coefficients. Per input sample it drives the downstream 16x16 accumulating MAC (clear, five operand pairs with clock-enable), waits out the MAC latency, then reads back the 32-bit Q4.28 sum. It rescales the sum to Q2.14 and emits y[n] to the next EQ stage.

---
 rtl/biquad_sequencer.sv | 159 +++++++++++++++
 tb/tb_biquad_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : biquad_sequencer
// Description : Sequences one biquad sample through an external 16x16
//               accumulating MAC and rescales the Q4.28 sum to a Q2.14 y[n].
//               Define BIQUAD_SAT_EN to clamp out-of-range results.
// Revision    : 1.0 - initial release
// ============================================================================
module biquad_sequencer #(
    parameter int MAC_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    input  logic [15:0] b0,
    input  logic [15:0] b1,
    input  logic [15:0] b2,
    input  logic [15:0] a1,
    input  logic [15:0] a2,
    output logic        mac_clr_n,
    output logic        mac_ce,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    input  logic [31:0] mac_result,
    output logic [15:0] y_out,
    output logic        y_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_MAC     = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    localparam logic [3:0] C_MAC_LAST   = 4'd4;
    localparam logic [3:0] C_DRAIN_LAST = 4'(MAC_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_x0, r_x1, r_x2, r_y1, r_y2;
    logic [15:0] r_b0, r_b1, r_b2, r_a1, r_a2;
    logic [15:0] w_neg_a1, w_neg_a2;
    logic [15:0] w_y;

    // Feedback terms are subtracted; -0x8000 is not representable so it pins to 0x7FFF.
    function automatic logic [15:0] sat_neg(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
    endfunction

    assign w_neg_a1 = sat_neg(r_a1);
    assign w_neg_a2 = sat_neg(r_a2);

`ifdef BIQUAD_SAT_EN
    logic signed [17:0] w_scaled;
    assign w_scaled = 18'($signed(mac_result) >>> 14);
    always_comb begin
        w_y = w_scaled[15:0];
        if (w_scaled > 18'sd32767)
            w_y = 16'h7FFF;
        else if (w_scaled < -18'sd32768)
            w_y = 16'h8000;
    end
`else
    assign w_y = 16'($signed(mac_result) >>> 14);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mac_clr_n = 1'b1;
        mac_ce    = 1'b0;
        mac_a     = 16'd0;
        mac_b     = 16'd0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (sample_valid)
                    w_next = S_CLR;
            end
            S_CLR: begin
                mac_clr_n = 1'b0;
                w_next    = S_MAC;
            end
            S_MAC: begin
                mac_ce = 1'b1;
                case (r_cnt)
                    4'd0:    begin mac_a = r_b0;     mac_b = r_x0; end
                    4'd1:    begin mac_a = r_b1;     mac_b = r_x1; end
                    4'd2:    begin mac_a = r_b2;     mac_b = r_x2; end
                    4'd3:    begin mac_a = w_neg_a1; mac_b = r_y1; end
                    default: begin mac_a = w_neg_a2; mac_b = r_y2; end
                endcase
                if (r_cnt == C_MAC_LAST)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == C_DRAIN_LAST)
                    w_next = S_CAPTURE;
            end
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // r_cnt restarts on every state change, so it indexes both MAC steps and drain cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_x0      <= 16'd0;
            r_x1      <= 16'd0;
            r_x2      <= 16'd0;
            r_y1      <= 16'd0;
            r_y2      <= 16'd0;
            r_b0      <= 16'd0;
            r_b1      <= 16'd0;
            r_b2      <= 16'd0;
            r_a1      <= 16'd0;
            r_a2      <= 16'd0;
            y_out     <= 16'd0;
            y_valid   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
            overrun <= sample_valid && (r_state != S_IDLE);
            y_valid <= 1'b0;
            if (r_state == S_IDLE && sample_valid) begin
                r_x0 <= sample_in;
                r_b0 <= b0;
                r_b1 <= b1;
                r_b2 <= b2;
                r_a1 <= a1;
                r_a2 <= a2;
            end
            if (r_state == S_CAPTURE) begin
                y_out   <= w_y;
                y_valid <= 1'b1;
                r_x2    <= r_x1;
                r_x1    <= r_x0;
                r_y2    <= r_y1;
                r_y1    <= w_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_biquad_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_biquad_sequencer
// Description : Self-checking bench for biquad_sequencer with a behavioural
//               MAC, a sample-level reference model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_biquad_sequencer;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = 16'd0;
    logic [15:0] b0 = 16'd0, b1 = 16'd0, b2 = 16'd0, a1 = 16'd0, a2 = 16'd0;
    logic        mac_clr_n, mac_ce, y_valid, busy, overrun;
    logic [15:0] mac_a, mac_b, y_out;
    logic [31:0] mac_result;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    biquad_sequencer #(.MAC_LAT(L)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .mac_clr_n(mac_clr_n), .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b),
        .mac_result(mac_result), .y_out(y_out), .y_valid(y_valid),
        .busy(busy), .overrun(overrun)
    );

    // Downstream MAC: sum is final L cycles after the last clock-enable cycle.
    logic signed [31:0] acc = 32'sd0;
    logic [31:0] pipe [L] = '{default: 32'd0};
    always @(posedge clk) begin
        if (!mac_clr_n)
            acc <= 32'sd0;
        else if (mac_ce)
            acc <= acc + $signed(mac_a) * $signed(mac_b);
        pipe[0] <= acc;
        for (int i = 1; i < L; i++)
            pipe[i] <= pipe[i-1];
    end
    assign mac_result = pipe[L-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [15:0] neg_sat(input logic [15:0] v);
        int t;
        t = -int'($signed(v));
        if (t > 32767)
            t = 32767;
        return 16'(t);
    endfunction

    // Reference model: one difference-equation evaluation per accepted sample.
    int          cyc = 0;
    bit          job = 1'b0;
    int          jn = 0;
    int          ovr = -1;
    logic [15:0] oa [5];
    logic [15:0] ob [5];
    logic [15:0] jy = 16'd0, yprev = 16'd0;
    logic [15:0] hx1 = 16'd0, hx2 = 16'd0, hy1 = 16'd0, hy2 = 16'd0;

    initial begin
        int s, sh;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                job = 1'b0; jy = 16'd0; yprev = 16'd0; ovr = -1;
                hx1 = 16'd0; hx2 = 16'd0; hy1 = 16'd0; hy2 = 16'd0;
            end else if (sample_valid) begin
                if (!job || (cyc - jn) >= 8 + L) begin
                    if (job)
                        yprev = jy;
                    oa = '{b0, b1, b2, neg_sat(a1), neg_sat(a2)};
                    ob = '{sample_in, hx1, hx2, hy1, hy2};
                    s = 0;
                    for (int k = 0; k < 5; k++)
                        s += int'($signed(oa[k])) * int'($signed(ob[k]));
                    sh = s >>> 14;
`ifdef BIQUAD_SAT_EN
                    if (sh > 32767) sh = 32767;
                    if (sh < -32768) sh = -32768;
`endif
                    jy  = 16'(sh);
                    hx2 = hx1; hx1 = sample_in; hy2 = hy1; hy1 = jy;
                    job = 1'b1;
                    jn  = cyc;
                end else begin
                    ovr = cyc;
                end
            end
        end
    end

    initial begin
        int d;
        logic [15:0] ea, eb;
        bit e_ce;
        forever begin
            @(negedge clk);
            d = job ? (cyc - jn) : -1000;
            e_ce = job && d >= 1 && d <= 5;
            ea = 16'd0;
            eb = 16'd0;
            if (e_ce) begin
                ea = oa[d-1];
                eb = ob[d-1];
            end
            chk("busy",      busy,      job && d >= 0 && d <= 6 + L);
            chk("mac_clr_n", mac_clr_n, !(job && d == 0));
            chk("mac_ce",    mac_ce,    e_ce);
            chk("mac_a",     mac_a,     ea);
            chk("mac_b",     mac_b,     eb);
            chk("y_valid",   y_valid,   job && d == 7 + L);
            chk("y_out",     y_out,     (job && d >= 7 + L) ? jy : yprev);
            chk("overrun",   overrun,   ovr == cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rst y_out", y_out, 16'd0);
        chk("rst busy", busy, 1'b0);
        chk("rst ce/clr", {mac_ce, mac_clr_n, y_valid}, 3'b010);
        chk("rst operands", {mac_a, mac_b}, 32'd0);
        @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] x);
        @(negedge clk); #2;
        sample_in = x;
        sample_valid = 1'b1;
        @(posedge clk); #2;
        sample_valid = 1'b0;
    endtask

    task automatic do_sample(input logic [15:0] x, input logic [15:0] exp, input string nm,
                             input bit scramble, input bit chk_k3);
        int ce_n, clr_n, lat;
        logic [15:0] yv, ak3;
        logic [15:0] sv [5];
        ce_n = 0; clr_n = 0; lat = -1; yv = 16'd0; ak3 = 16'd0;
        strobe(x);
        sv = '{b0, b1, b2, a1, a2};
        if (scramble) begin
            b0 = 16'h1234; b1 = 16'h5A5A; b2 = 16'h7FFF; a1 = 16'h8000; a2 = 16'h4321;
        end
        for (int d = 0; d < 40 && lat < 0; d++) begin
            @(negedge clk);
            if (mac_ce) ce_n++;
            if (!mac_clr_n) clr_n++;
            if (d == 4) ak3 = mac_a;
            if (y_valid) begin
                lat = d;
                yv = y_out;
            end
        end
        b0 = sv[0]; b1 = sv[1]; b2 = sv[2]; a1 = sv[3]; a2 = sv[4];
        chk({nm, " latency"}, 32'(lat), 32'd10);
        chk({nm, " ce cycles"}, 32'(ce_n), 32'd5);
        chk({nm, " clr cycles"}, 32'(clr_n), 32'd1);
        chk({nm, " y"}, yv, exp);
        if (chk_k3)
            chk({nm, " k3 mac_a"}, ak3, 16'h2000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nov, nyv;
        logic [15:0] yv;
        repeat (3) @(negedge clk);
        chk("reset y_out", y_out, 16'd0);
        chk("reset flags", {busy, y_valid, overrun, mac_clr_n}, 4'b0001);
        #2 reset = 1'b0;

        // Unity gain.
        b0 = 16'h4000;
        do_sample(16'h2000, 16'h2000, "t1", 1'b0, 1'b0);

        // Feed-forward tap.
        do_reset();
        b1 = 16'h2000;
        do_sample(16'h4000, 16'h4000, "t2a", 1'b0, 1'b0);
        do_sample(16'h0000, 16'h2000, "t2b", 1'b0, 1'b0);

        // Feedback tap; coefficients scrambled while the second sample is in flight.
        do_reset();
        b1 = 16'h0000; a1 = 16'hE000;
        do_sample(16'h4000, 16'h4000, "t3a", 1'b0, 1'b1);
        do_sample(16'h0000, 16'h2000, "t3b", 1'b1, 1'b1);
        do_sample(16'h0000, 16'h1000, "t3c", 1'b0, 1'b1);

        // Full-scale product overflows Q2.14.
        do_reset();
        b0 = 16'h7FFF; a1 = 16'h0000;
`ifdef BIQUAD_SAT_EN
        do_sample(16'h7FFF, 16'h7FFF, "t4", 1'b0, 1'b0);
`else
        do_sample(16'h7FFF, 16'hFFFC, "t4", 1'b0, 1'b0);
`endif

        // Negating a1 = -2.0 must saturate.
        do_reset();
        b0 = 16'h4000; a1 = 16'h8000;
        do_sample(16'h0100, 16'h0100, "tneg_a", 1'b0, 1'b0);
        do_sample(16'h0000, 16'h01FF, "tneg_b", 1'b0, 1'b0);

        // Second strobe three cycles after the first.
        do_reset();
        a1 = 16'h0000;
        strobe(16'h1000);
        repeat (3) @(negedge clk);
        #2 sample_in = 16'h7000;
        sample_valid = 1'b1;
        @(posedge clk); #2 sample_valid = 1'b0;
        nov = 0; nyv = 0; yv = 16'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (overrun) nov++;
            if (y_valid) begin nyv++; yv = y_out; end
        end
        chk("t5 overrun pulses", 32'(nov), 32'd1);
        chk("t5 y_valid pulses", 32'(nyv), 32'd1);
        chk("t5 y", yv, 16'h1000);

        // Strobe accepted on the y_valid cycle.
        strobe(16'h0400);
        nyv = 0;
        for (int i = 0; i < 40 && !y_valid; i++) @(negedge clk);
        #2 sample_in = 16'h0200;
        sample_valid = 1'b1;
        @(posedge clk); #2 sample_valid = 1'b0;
        nov = 0; yv = 16'd0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (overrun) nov++;
            if (y_valid) begin nyv++; yv = y_out; end
        end
        chk("t7 overrun", 32'(nov), 32'd0);
        chk("t7 y_valid", 32'(nyv), 32'd1);
        chk("t7 y", yv, 16'h0200);

        // Reset during DRAIN clears history.
        do_reset();
        b0 = 16'h4000; b1 = 16'h4000;
        do_sample(16'h1000, 16'h1000, "t6a", 1'b0, 1'b0);
        strobe(16'h2000);
        repeat (6) @(negedge clk);
        do_reset();
        nyv = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (y_valid) nyv++;
        end
        chk("t6 y_valid after reset", 32'(nyv), 32'd0);
        do_sample(16'h0800, 16'h0800, "t6b", 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
